// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: redirect in, imem request/response, decode handshake.
// master = fetch_ctrl side; slave = surrounding pipeline and memory.
interface fetch_ctrl_if #(
    parameter int N = 64
);
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [N-1:0] imem_req_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst_data;
    logic [N-1:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer with one outstanding imem request and a one-entry decode buffer; redirect kills everything.
// Latency: response at t+k gives inst_valid at t+k+1; decode backpressure parks the FSM in HOLD.
module fetch_ctrl #(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    localparam logic [N-1:0] PC_STEP = 4;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_pc;
    logic [N-1:0] w_pc_nxt;
    logic [N-1:0] r_req_pc;
    logic [N-1:0] w_req_pc_nxt;
    logic [N-1:0] r_inst_pc;
    logic [N-1:0] w_inst_pc_nxt;
    logic [31:0]  r_inst_data;
    logic [31:0]  w_inst_data_nxt;
    logic         w_req_valid;
    logic         w_inst_valid;
    logic         w_redir;

    assign w_redir = bus.redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= BOOT;
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_inst_pc   <= '0;
            r_inst_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_req_pc    <= w_req_pc_nxt;
            r_inst_pc   <= w_inst_pc_nxt;
            r_inst_data <= w_inst_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_req_pc_nxt    = r_req_pc;
        w_inst_pc_nxt   = r_inst_pc;
        w_inst_data_nxt = r_inst_data;
        w_req_valid     = 1'b0;
        w_inst_valid    = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = REQ;
                if (w_redir) begin
                    w_pc_nxt = bus.redirect_pc;
                end
            end
            REQ: begin
                w_req_valid = !w_redir;
                if (w_redir) begin
                    w_pc_nxt = bus.redirect_pc;
                end else if (bus.imem_req_ready) begin
                    w_req_pc_nxt = r_pc;
                    w_pc_nxt     = r_pc + PC_STEP;
                    w_state_nxt  = WAIT;
                end
            end
            WAIT: begin
                // A redirect without the response must still drain the killed one in DROP.
                if (w_redir) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = bus.imem_rsp_valid ? REQ : DROP;
                end else if (bus.imem_rsp_valid) begin
                    w_inst_data_nxt = bus.imem_rsp_data;
                    w_inst_pc_nxt   = r_req_pc;
                    w_state_nxt     = HOLD;
                end
            end
            DROP: begin
                if (w_redir) begin
                    w_pc_nxt = bus.redirect_pc;
                end
                if (bus.imem_rsp_valid) begin
                    w_state_nxt = REQ;
                end
            end
            HOLD: begin
                w_inst_valid = !w_redir;
                if (w_redir) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = REQ;
                end else if (bus.inst_ready) begin
                    w_state_nxt = REQ;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst_data      = r_inst_data;
    assign bus.inst_pc        = r_inst_pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Random redirects, memory latency, backpressure and mid-run resets against a transaction-level fetch model.
// A short directed boot run (1-cycle memory, no stalls) opens the sequence.
module tb_fetch_ctrl;
    localparam int           N      = 64;
    localparam logic [N-1:0] RST_PC = 64'h1000;
    localparam int           NCYC   = 3000;

    logic clk;
    logic reset;

    fetch_ctrl_if #(.N(N)) bus ();

    fetch_ctrl #(.N(N), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, act, exp);
        end
    endtask

    // Model: a pending boot cycle, at most one outstanding fetch (possibly killed), one buffered instruction.
    bit           m_boot, m_busy, m_kill, m_buf;
    logic [N-1:0] m_pc, m_req_pc, m_buf_pc;
    logic [31:0]  m_buf_dat;

    bit           mem_pend;
    int           mem_due;
    logic [31:0]  mem_dat;
    int           dir_n;
    int           bp_cnt;

    task automatic model_reset();
        m_boot   = 1'b1;
        m_busy   = 1'b0;
        m_kill   = 1'b0;
        m_buf    = 1'b0;
        m_pc     = RST_PC;
        m_req_pc = '0;
        m_buf_pc = '0;
        m_buf_dat = '0;
        mem_pend = 1'b0;
    endtask

    function automatic logic [N-1:0] pick_target();
        logic [N-1:0] t;
        case ($urandom_range(0, 6))
            0: t = 64'h2000;
            1: t = 64'h3000;
            2: t = 64'h4000;
            3: t = 64'h5000;
            4: t = '0 - 64'd4;
            5: t = '0 - 64'd8;
            default: t = {32'h0, $urandom} & ~64'h3;
        endcase
        return t;
    endfunction

    task automatic drive_idle();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
    endtask

    initial begin
        bit           dirph;
        bit           exp_req, exp_inst, redir, rsp;
        logic [N-1:0] tgt;
        int           lat;
        logic [31:0]  new_dat;

        reset = 1'b1;
        drive_idle();
        dir_n  = 0;
        bp_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_vld", {63'd0, bus.imem_req_valid}, 64'd0);
        chk("rst_inst_vld", {63'd0, bus.inst_valid}, 64'd0);
        chk("rst_addr", bus.imem_req_addr, RST_PC);
        chk("rst_inst_pc", bus.inst_pc, 64'd0);
        chk("rst_inst_dat", {32'd0, bus.inst_data}, 64'd0);
        reset = 1'b0;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            if (cyc > 40 && $urandom_range(0, 149) == 0) begin
                reset = 1'b1;
                #1;
                chk("arst_req_vld", {63'd0, bus.imem_req_valid}, 64'd0);
                chk("arst_inst_vld", {63'd0, bus.inst_valid}, 64'd0);
                chk("arst_addr", bus.imem_req_addr, RST_PC);
                drive_idle();
                @(posedge clk);
                #1;
                reset = 1'b0;
                model_reset();
            end

            dirph = (cyc < 12);
            rsp   = mem_pend && (cyc == mem_due);
            redir = dirph ? 1'b0 : ($urandom_range(0, 9) == 0);
            tgt   = pick_target();
            bus.redirect_valid = redir;
            bus.redirect_pc    = tgt;
            bus.imem_rsp_valid = rsp;
            bus.imem_rsp_data  = rsp ? mem_dat : $urandom;
            bus.imem_req_ready = dirph ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (dirph) begin
                bus.inst_ready = 1'b1;
            end else if (bp_cnt > 0) begin
                bus.inst_ready = 1'b0;
                bp_cnt--;
            end else begin
                bus.inst_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) bp_cnt = 5;
            end
            #1;

            exp_req  = !m_boot && !m_busy && !m_buf && !redir;
            exp_inst = m_buf && !redir;
            chk("req_vld", {63'd0, bus.imem_req_valid}, {63'd0, exp_req});
            chk("req_addr", bus.imem_req_addr, m_pc);
            chk("inst_vld", {63'd0, bus.inst_valid}, {63'd0, exp_inst});
            if (exp_inst) begin
                chk("inst_pc", bus.inst_pc, m_buf_pc);
                chk("inst_dat", {32'd0, bus.inst_data}, {32'd0, m_buf_dat});
            end

            if (rsp) mem_pend = 1'b0;
            if (exp_req && bus.imem_req_ready) begin
                lat      = dirph ? 1 : int'($urandom_range(1, 4));
                new_dat  = dirph ? (32'hA + dir_n) : $urandom;
                dir_n++;
                mem_pend = 1'b1;
                mem_due  = cyc + lat;
                mem_dat  = new_dat;
            end

            if (m_boot) begin
                if (redir) m_pc = tgt;
                m_boot = 1'b0;
            end else if (m_buf) begin
                if (redir) begin
                    m_buf = 1'b0;
                    m_pc  = tgt;
                end else if (bus.inst_ready) begin
                    m_buf = 1'b0;
                end
            end else if (m_busy) begin
                if (rsp) begin
                    m_busy = 1'b0;
                    if (!m_kill && !redir) begin
                        m_buf     = 1'b1;
                        m_buf_pc  = m_req_pc;
                        m_buf_dat = bus.imem_rsp_data;
                    end
                    m_kill = 1'b0;
                end else if (redir) begin
                    m_kill = 1'b1;
                end
                if (redir) m_pc = tgt;
            end else begin
                if (redir) begin
                    m_pc = tgt;
                end else if (bus.imem_req_ready) begin
                    m_req_pc = m_pc;
                    m_pc     = m_pc + 64'd4;
                    m_busy   = 1'b1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
